// File: rtl/demux_1_16.sv
// demux_1_16: registered 1-to-16 word collector with valid/ready input
// and frame hold/ack handshake. Optional frame_xor via DEMUX_1_16_XOR_EN.
module demux_1_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             auto,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic [WIDTH-1:0] out8,
    output logic [WIDTH-1:0] out9,
    output logic [WIDTH-1:0] out10,
    output logic [WIDTH-1:0] out11,
    output logic [WIDTH-1:0] out12,
    output logic [WIDTH-1:0] out13,
    output logic [WIDTH-1:0] out14,
    output logic [WIDTH-1:0] out15,
    output logic [15:0]      lane_mask,
    output logic             frame_valid,
`ifdef DEMUX_1_16_XOR_EN
    output logic [WIDTH-1:0] frame_xor,
`endif
    input  logic             frame_ack
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] lanes [16];
    logic [15:0]      mask;
    logic [3:0]       ptr;
    logic [3:0]       lane;
    logic [15:0]      lane_bit;
    logic             accept;
    logic             release_frame;

    assign lane          = auto ? ptr : sel;
    assign lane_bit      = 16'(1) << lane;
    assign accept        = in_valid && in_ready;
    assign release_frame = (state == HOLD) && frame_ack;

    // State register; reset wins over any accept or ack
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state: frame completes when the accepted lane fills the mask
    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (accept && ((mask | lane_bit) == 16'hFFFF)) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Handshake outputs decoded from registered state only
    always_comb begin
        in_ready    = (state == FILL);
        frame_valid = (state == HOLD);
    end

    // Lane datapath, mask and pointer; lanes survive a frame release
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                lanes[i] <= '0;
            end
            mask <= '0;
            ptr  <= '0;
        end else if (accept) begin
            lanes[lane] <= din;
            mask        <= mask | lane_bit;
            if (auto) begin
                ptr <= ptr + 4'd1;
            end
        end else if (release_frame) begin
            mask <= '0;
            ptr  <= '0;
        end
    end

`ifdef DEMUX_1_16_XOR_EN
    // Running XOR of every accepted word, overwrites included
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_xor <= '0;
        end else if (accept) begin
            frame_xor <= frame_xor ^ din;
        end else if (release_frame) begin
            frame_xor <= '0;
        end
    end
`endif

    assign lane_mask = mask;
    assign out0  = lanes[0];
    assign out1  = lanes[1];
    assign out2  = lanes[2];
    assign out3  = lanes[3];
    assign out4  = lanes[4];
    assign out5  = lanes[5];
    assign out6  = lanes[6];
    assign out7  = lanes[7];
    assign out8  = lanes[8];
    assign out9  = lanes[9];
    assign out10 = lanes[10];
    assign out11 = lanes[11];
    assign out12 = lanes[12];
    assign out13 = lanes[13];
    assign out14 = lanes[14];
    assign out15 = lanes[15];

endmodule
